// File: rtl/jtag_dtm_dmi_ctrl.sv
// jtag_dtm_dmi_ctrl
// DTM data registers (DTMCS and DMI access) with a valid/ready request and
// valid-only response handshake toward the Debug Module.
//
// Ports
//   Capture_clk            TCK; all state on posedge
//   TRST                   asynchronous active-low reset
//   Reset                  TAP in Test-Logic-Reset, synchronous clear
//   TDI                    serial data in (enters the selected register MSB)
//   Capture_DR/Shift_DR/Update_DR   TAP DR phase strobes
//   dtm_csr_sel            IR selects DTMCS
//   dmi_access_sel         IR selects DMI access
//   dtm_csr_shift_out      DTMCS shift register bit 0
//   dmi_access_shift_out   DMI shift register bit 0
//   dmi_req_*              request channel to the DM (op 1=READ, 2=WRITE)
//   dmi_rsp_*              response channel from the DM (op 0=ok, 2=failed, 3=busy)
//
// state    | meaning
// ST_IDLE  | no transaction outstanding, DMI updates may launch a request
// ST_REQ   | request presented, waiting for dmi_req_ready
// ST_WAIT  | request accepted, waiting for dmi_rsp_valid
module jtag_dtm_dmi_ctrl #(
    parameter int unsigned ABITS   = 7,
    parameter int unsigned DWIDTH  = 32,
    parameter logic [2:0]  IDLE    = 3'd1,
    parameter logic [3:0]  VERSION = 4'd1
) (
    input  logic              Capture_clk,
    input  logic              TRST,
    input  logic              Reset,
    input  logic              TDI,
    input  logic              Capture_DR,
    input  logic              Shift_DR,
    input  logic              Update_DR,
    input  logic              dtm_csr_sel,
    input  logic              dmi_access_sel,
    output logic              dtm_csr_shift_out,
    output logic              dmi_access_shift_out,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic [ABITS-1:0]  dmi_req_addr,
    output logic [DWIDTH-1:0] dmi_req_data,
    output logic [1:0]        dmi_req_op,
    input  logic              dmi_rsp_valid,
    input  logic [DWIDTH-1:0] dmi_rsp_data,
    input  logic [1:0]        dmi_rsp_op
);

    localparam int unsigned DMI_W   = ABITS + DWIDTH + 2;
    localparam logic [5:0]  ABITS_F = 6'(ABITS);
    localparam logic [1:0]  OP_READ  = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       dtmcs_sr_q, dtmcs_sr_d;
    logic [DMI_W-1:0]  dmi_sr_q, dmi_sr_d;
    logic [1:0]        stat_q, stat_d;
    logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ABITS-1:0]  last_addr_q, last_addr_d;
    logic [ABITS-1:0]  req_addr_q, req_addr_d;
    logic [DWIDTH-1:0] req_data_q, req_data_d;
    logic [1:0]        req_op_q, req_op_d;

    logic              dtm_upd, hardreset, dmireset;
    logic              dmi_cap, dmi_upd, launch, rsp_take, busy;
    logic [1:0]        cap_op;
    logic [ABITS-1:0]  upd_addr;
    logic [DWIDTH-1:0] upd_data;
    logic [1:0]        upd_op;

    // DTMCS update acts even alongside a capture: hardreset outranks it.
    assign dtm_upd   = Update_DR && dtm_csr_sel;
    assign hardreset = dtm_upd && dtmcs_sr_q[17];
    assign dmireset  = dtm_upd && dtmcs_sr_q[16] && !dtmcs_sr_q[17];

    assign dmi_cap  = Capture_DR && dmi_access_sel;
    assign dmi_upd  = Update_DR && dmi_access_sel && !Capture_DR && !Shift_DR;
    assign busy     = (state_q != ST_IDLE);
    assign cap_op   = busy ? 2'd3 : stat_q;

    assign upd_addr = dmi_sr_q[DMI_W-1 -: ABITS];
    assign upd_data = dmi_sr_q[DWIDTH+1:2];
    assign upd_op   = dmi_sr_q[1:0];

    assign launch   = dmi_upd && (stat_q == 2'd0) && !busy &&
                      ((upd_op == OP_READ) || (upd_op == OP_WRITE));
    assign rsp_take = (state_q == ST_WAIT) && dmi_rsp_valid;

    // FSM state register
    always_ff @(posedge Capture_clk or negedge TRST) begin
        if (!TRST) begin
            state_q <= ST_IDLE;
        end else if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch)        state_d = ST_REQ;
            ST_REQ:  if (dmi_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (dmi_rsp_valid) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
        if (hardreset) begin
            state_d = ST_IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        dmi_req_valid = (state_q == ST_REQ);
    end

    // Datapath next state
    always_comb begin
        dtmcs_sr_d  = dtmcs_sr_q;
        dmi_sr_d    = dmi_sr_q;
        stat_d      = stat_q;
        rsp_data_d  = rsp_data_q;
        last_addr_d = last_addr_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;

        if (Capture_DR && dtm_csr_sel) begin
            dtmcs_sr_d = {14'd0, 1'b0, 1'b0, 1'b0, IDLE, stat_q, ABITS_F, VERSION};
        end else if (Shift_DR && dtm_csr_sel) begin
            dtmcs_sr_d = {TDI, dtmcs_sr_q[31:1]};
        end

        if (dmi_cap) begin
            dmi_sr_d = {last_addr_q, rsp_data_q, cap_op};
        end else if (Shift_DR && dmi_access_sel) begin
            dmi_sr_d = {TDI, dmi_sr_q[DMI_W-1:1]};
        end

        // stat is sticky: each error source only writes while it is still clear
        if (dmireset) begin
            stat_d = 2'd0;
        end
        if (rsp_take && (stat_d == 2'd0)) begin
            case (dmi_rsp_op)
                2'd1, 2'd2: stat_d = 2'd2;
                2'd3:       stat_d = 2'd3;
                default:    stat_d = stat_d;
            endcase
        end
        if (dmi_cap && busy && (stat_d == 2'd0)) begin
            stat_d = 2'd3;
        end
        if (dmi_upd && (stat_q == 2'd0) && busy && (stat_d == 2'd0)) begin
            stat_d = 2'd3;
        end

        if (rsp_take && (req_op_q == OP_READ)) begin
            rsp_data_d = dmi_rsp_data;
        end

        if (launch) begin
            req_addr_d  = upd_addr;
            req_data_d  = upd_data;
            req_op_d    = upd_op;
            last_addr_d = upd_addr;
        end

        if (hardreset) begin
            stat_d     = 2'd0;
            rsp_data_d = '0;
        end
    end

    always_ff @(posedge Capture_clk or negedge TRST) begin
        if (!TRST) begin
            dtmcs_sr_q  <= '0;
            dmi_sr_q    <= '0;
            stat_q      <= '0;
            rsp_data_q  <= '0;
            last_addr_q <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
        end else if (Reset) begin
            dtmcs_sr_q  <= '0;
            dmi_sr_q    <= '0;
            stat_q      <= '0;
            rsp_data_q  <= '0;
            last_addr_q <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
        end else begin
            dtmcs_sr_q  <= dtmcs_sr_d;
            dmi_sr_q    <= dmi_sr_d;
            stat_q      <= stat_d;
            rsp_data_q  <= rsp_data_d;
            last_addr_q <= last_addr_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
        end
    end

    assign dtm_csr_shift_out    = dtmcs_sr_q[0];
    assign dmi_access_shift_out = dmi_sr_q[0];
    assign dmi_req_addr         = req_addr_q;
    assign dmi_req_data         = req_data_q;
    assign dmi_req_op           = req_op_q;

endmodule
